// File: rtl/apb_slave_mem_checked_if.sv
// APB3 bus bundle between a master (test environment) and the checked memory slave.
interface apb_slave_mem_checked_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem_checked.sv
// APB3 word-addressed register memory with wait states and a protocol checker
// exposing sticky violation flags; erroring transfers raise PSLVERR and never write.
module apb_slave_mem_checked #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  apb_slave_mem_checked_if.slave apb,
  input  logic                   viol_clr,
  output logic [6:0]             viol_flags,
  output logic [15:0]            xfer_cnt
);
  localparam int OFF  = $clog2(DATA_WIDTH / 8);
  localparam int IDXW = ADDR_WIDTH - OFF;
  localparam int MW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [3:0]            wcnt_q;
  logic                  err_q;
  logic [6:0]            flags_q;
  logic [6:0]            flags_d;
  logic [15:0]           cnt_q;
  logic [15:0]           cnt_d;

  logic                  in_access;
  logic                  ready;
  logic                  addr_mm;
  logic                  wr_mm;
  logic                  data_mm;
  logic                  abort;
  logic                  oor;
  logic                  misal;
  logic                  slverr;
  logic                  done_read;
  logic                  mem_we;
  logic [IDXW-1:0]       idx;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [6:0]            det;
  logic [DATA_WIDTH-1:0] rd_words [DEPTH];

  assign in_access = (state_q == ACCESS);
  assign ready     = in_access && (wcnt_q == 4'd0);
  assign idx       = addr_q[ADDR_WIDTH-1:OFF];
  assign oor       = ({1'b0, idx} >= (IDXW + 1)'(DEPTH));

  generate
    if (ALIGN_CHECK != 0 && OFF > 0) begin : g_align
      assign misal = |addr_q[OFF-1:0];
    end else begin : g_noalign
      assign misal = 1'b0;
    end
  endgenerate

  // The bus must hold the setup values for the whole access phase.
  assign addr_mm = in_access && (apb.PADDR != addr_q);
  assign wr_mm   = in_access && (apb.PWRITE != write_q);
  assign data_mm = in_access && write_q && (apb.PWDATA != wdata_q);
  assign abort   = in_access && !ready && !(apb.PSEL && apb.PENABLE);

  assign slverr    = ready && (oor || misal || err_q || addr_mm || wr_mm || data_mm);
  assign done_read = ready && !write_q;
  assign mem_we    = ready && write_q && !slverr;
  assign rd_val    = slverr ? '0 : rd_words[idx[MW-1:0]];

  assign apb.PREADY  = ready;
  assign apb.PSLVERR = slverr;
  assign apb.PRDATA  = done_read ? rd_val : prdata_q;

  assign det[0] = (state_q == IDLE) && apb.PENABLE;
  assign det[1] = addr_mm;
  assign det[2] = wr_mm;
  assign det[3] = data_mm;
  assign det[4] = abort;
  assign det[5] = ready && oor;
  assign det[6] = ready && misal;

  // A clear in the same cycle as a detection leaves the new detection set.
  assign flags_d = (viol_clr ? 7'd0 : flags_q) | det;
  assign cnt_d   = (ready && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  assign viol_flags = flags_q;
  assign xfer_cnt   = cnt_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      prdata_q <= '0;
      wcnt_q   <= 4'd0;
      err_q    <= 1'b0;
      flags_q  <= 7'd0;
      cnt_q    <= 16'd0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      if (done_read) begin
        prdata_q <= rd_val;
      end
      case (state_q)
        IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            addr_q  <= apb.PADDR;
            write_q <= apb.PWRITE;
            wdata_q <= apb.PWDATA;
            wcnt_q  <= 4'(WAIT_STATES);
            err_q   <= 1'b0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (ready || abort) begin
            state_q <= IDLE;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
            err_q  <= err_q | addr_mm | wr_mm | data_mm;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] word_q;
      always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
          word_q <= '0;
        end else if (mem_we && idx == IDXW'(gi)) begin
          word_q <= wdata_q;
        end
      end
      assign rd_words[gi] = word_q;
    end
  endgenerate
endmodule

// File: tb/tb_apb_slave_mem_checked.sv
// Random and directed APB traffic with protocol violations, checked against a
// transaction-level model of memory contents, violation flags and transfer count.
module tb_apb_slave_mem_checked;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        viol_clr = 1'b0;
  logic [6:0]  viol_flags;
  logic [15:0] xfer_cnt;

  apb_slave_mem_checked_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_slave_mem_checked #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS), .ALIGN_CHECK(1)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus),
    .viol_clr(viol_clr), .viol_flags(viol_flags), .xfer_cnt(xfer_cnt)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  int n_xfer = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [6:0]    flags_m;
  int            cnt_m;
  logic [DW-1:0] prdata_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    flags_m  = '0;
    cnt_m    = 0;
    prdata_m = '0;
  endtask

  task automatic drive_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
  endtask

  // kind: 0 clean, 1 PADDR change, 2 PWRITE flip, 3 PWDATA change, 4 PSEL drop, 5 PENABLE drop;
  // k is the access-phase cycle in which the disturbance is applied.
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                      input bit pre, input int kind, input int k,
                      input bit clr_done, input bit clr_idle,
                      output logic [DW-1:0] rd_o, output logic err_o);
    logic [6:0]    det;
    logic [DW-1:0] exp_rd;
    bit            errd, oor, mis, exp_err, aborted;
    int            idx;
    rd_o    = '0;
    err_o   = 1'b0;
    errd    = 1'b0;
    aborted = 1'b0;
    idx     = int'(a >> 2);
    oor     = (idx >= DEPTH);
    mis     = (a[1:0] != 2'b00);
    if (pre) begin
      @(posedge PCLK); #1;
      viol_clr    = 1'b0;
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b1;
      bus.PADDR   = AW'($urandom);
      bus.PWRITE  = 1'($urandom);
      bus.PWDATA  = $urandom;
      @(negedge PCLK);
      chk("pre_pready", bus.PREADY, 1'b0);
      flags_m[0] = 1'b1;
    end
    @(posedge PCLK); #1;
    viol_clr    = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = a;
    bus.PWRITE  = w;
    bus.PWDATA  = d;
    for (int cc = 0; cc <= WS; cc++) begin
      @(posedge PCLK); #1;
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b1;
      bus.PADDR   = a;
      bus.PWRITE  = w;
      bus.PWDATA  = d;
      viol_clr    = clr_done && (cc == WS);
      det = '0;
      if (cc == k) begin
        case (kind)
          1: begin bus.PADDR = a ^ AW'($urandom | 32'h1); det[1] = 1'b1; errd = 1'b1; end
          2: begin bus.PWRITE = ~w; det[2] = 1'b1; errd = 1'b1; end
          3: begin
            bus.PWDATA = d ^ ($urandom | 32'h1);
            if (w) begin det[3] = 1'b1; errd = 1'b1; end
          end
          4: begin bus.PSEL = 1'b0; det[4] = 1'b1; aborted = 1'b1; end
          5: begin bus.PENABLE = 1'b0; det[4] = 1'b1; aborted = 1'b1; end
          default: ;
        endcase
      end
      @(negedge PCLK);
      chk("pready", bus.PREADY, (cc == WS) && !aborted);
      if (aborted) begin
        chk("abort_pslverr", bus.PSLVERR, 1'b0);
        flags_m = (viol_clr ? 7'd0 : flags_m) | det;
        break;
      end
      if (cc == WS) begin
        exp_err = oor || mis || errd;
        det[5]  = oor;
        det[6]  = mis;
        chk("pslverr", bus.PSLVERR, exp_err);
        err_o = bus.PSLVERR;
        if (!w) begin
          exp_rd = exp_err ? '0 : mem_m[idx];
          chk("prdata", bus.PRDATA, exp_rd);
          rd_o     = bus.PRDATA;
          prdata_m = exp_rd;
        end else if (!exp_err) begin
          mem_m[idx] = d;
        end
        cnt_m++;
      end else begin
        chk("wait_pslverr", bus.PSLVERR, 1'b0);
      end
      flags_m = (viol_clr ? 7'd0 : flags_m) | det;
    end
    @(posedge PCLK); #1;
    drive_idle();
    viol_clr = clr_idle;
    @(negedge PCLK);
    chk("idle_pready", bus.PREADY, 1'b0);
    chk("idle_pslverr", bus.PSLVERR, 1'b0);
    chk("prdata_hold", bus.PRDATA, prdata_m);
    chk("flags", viol_flags, flags_m);
    chk("xfer_cnt", xfer_cnt, cnt_m);
    if (clr_idle) flags_m = '0;
    n_xfer++;
    $display("xfer %0d addr=%h wr=%0b data=%h pre=%0b kind=%0d k=%0d err=%0b rd=%h",
             n_xfer, a, w, d, pre, kind, k, err_o, rd_o);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    logic [AW-1:0] a;
    logic          w;
    int            kind, k, c0, r;

    drive_idle();
    model_reset();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", bus.PREADY, 1'b0);
    chk("rst_pslverr", bus.PSLVERR, 1'b0);
    chk("rst_prdata", bus.PRDATA, 32'h0);
    chk("rst_flags", viol_flags, 7'h0);
    chk("rst_cnt", xfer_cnt, 16'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    xfer(10'h004, 1'b1, 32'hDEADBEEF, 0, 0, 0, 0, 0, rd, er);
    xfer(10'h004, 1'b0, 32'h0, 0, 0, 0, 0, 0, rd, er);
    chk("t1_rd", rd, 32'hDEADBEEF);
    chk("t1_err", er, 1'b0);
    chk("t1_cnt", xfer_cnt, 16'd2);

    xfer(10'h008, 1'b0, 32'h0, 0, 0, 0, 0, 0, rd, er);
    chk("t2_rd", rd, 32'h0);

    xfer(10'h100, 1'b1, 32'h11223344, 0, 0, 0, 0, 0, rd, er);
    chk("t3_err", er, 1'b1);
    chk("t3_flag5", viol_flags[5], 1'b1);
    xfer(10'h000, 1'b0, 32'h0, 0, 0, 0, 0, 0, rd, er);
    chk("t3_rd0_err", er, 1'b0);

    xfer(10'h00C, 1'b1, 32'h12345678, 1, 1, 1, 0, 0, rd, er);
    chk("t4_err", er, 1'b1);
    chk("t4_flag0", viol_flags[0], 1'b1);
    chk("t4_flag1", viol_flags[1], 1'b1);
    xfer(10'h00C, 1'b0, 32'h0, 0, 0, 0, 0, 0, rd, er);
    chk("t4_mem3", rd, 32'h0);

    c0 = cnt_m;
    xfer(10'h010, 1'b1, 32'hCAFEF00D, 0, 4, 1, 0, 0, rd, er);
    chk("t5_flag4", viol_flags[4], 1'b1);
    chk("t5_cnt", xfer_cnt, 16'(c0));
    xfer(10'h010, 1'b1, 32'hCAFEF00D, 0, 0, 0, 0, 0, rd, er);
    xfer(10'h010, 1'b0, 32'h0, 0, 0, 0, 0, 0, rd, er);
    chk("t5_rd", rd, 32'hCAFEF00D);

    xfer(10'h005, 1'b1, 32'h55AA55AA, 0, 0, 0, 1, 0, rd, er);
    chk("t6_flags", viol_flags, 7'b1000000);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) a = AW'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 7) a = AW'($urandom_range(DEPTH, 255) * 4);
      else a = AW'($urandom);
      w = 1'($urandom);
      r = $urandom_range(0, 9);
      kind = (r < 5) ? 0 : r - 4;
      k = (kind >= 4) ? $urandom_range(0, WS - 1) : $urandom_range(0, WS);
      xfer(a, w, $urandom, ($urandom_range(0, 9) == 0), kind, k,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), rd, er);
    end

    for (int i = 0; i < DEPTH; i++) xfer(AW'(i * 4), 1'b0, 32'h0, 0, 0, 0, 0, 0, rd, er);

    // Reset in the middle of a write access phase.
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 10'h020;
    bus.PWRITE = 1'b1; bus.PWDATA = 32'hAAAA5555;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #2;
    PRESET = 1'b1;
    #1;
    chk("mrst_pready", bus.PREADY, 1'b0);
    chk("mrst_pslverr", bus.PSLVERR, 1'b0);
    chk("mrst_prdata", bus.PRDATA, 32'h0);
    chk("mrst_flags", viol_flags, 7'h0);
    chk("mrst_cnt", xfer_cnt, 16'h0);
    @(posedge PCLK); #1;
    drive_idle();
    PRESET = 1'b0;
    model_reset();

    xfer(10'h004, 1'b0, 32'h0, 0, 0, 0, 0, 0, rd, er);
    chk("mrst_rd4", rd, 32'h0);
    for (int i = 0; i < DEPTH; i++) xfer(AW'(i * 4), 1'b0, 32'h0, 0, 0, 0, 0, 0, rd, er);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
